// File: rtl/rvfi_dmem_check_pkg.sv
// Shared constants and address helpers for the RVFI data-memory checker.
// Word width follows the RVFI_DMEM_XLEN macro so the package matches the harness XLEN.
`ifndef RVFI_DMEM_XLEN
`define RVFI_DMEM_XLEN 32
`endif
`ifndef RVFORMAL_ADDR_VALID
`define RVFORMAL_ADDR_VALID(a) 1'b1
`endif

package rvfi_dmem_check_pkg;
    localparam int PKG_XLEN = `RVFI_DMEM_XLEN;
    localparam int BYTES    = PKG_XLEN / 8;
    localparam int LANE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef logic [PKG_XLEN-1:0] addr_t;
    typedef logic [LANE_W-1:0]   lane_t;

    // Byte lane of an address inside its aligned word.
    function automatic lane_t lane_of(input addr_t addr);
        return addr[LANE_W-1:0];
    endfunction

    // Aligned word address containing a byte address.
    function automatic addr_t word_of(input addr_t addr);
        return addr & ~addr_t'(BYTES - 1);
    endfunction
endpackage

// File: rtl/rvfi_dmem_shadow_word.sv
// One tracked word: byte-granular shadow data plus written bits, with a read view
// per slot that already includes stores from lower retire channels of the same cycle.
module rvfi_dmem_shadow_word
    import rvfi_dmem_check_pkg::*;
#(
    parameter int NRET = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NRET*BYTES-1:0]        wr_hit,
    input  logic [NRET*BYTES*LANE_W-1:0] lane,
    input  logic [NRET*BYTES*8-1:0]      wdata,
    output logic [NRET*BYTES-1:0]        rd_written,
    output logic [NRET*BYTES*8-1:0]      rd_data
);
    localparam int NSLOT = NRET * BYTES;

    // NOTE: shadow bytes have no reset; written_q alone says whether a byte is meaningful.
    logic [7:0]       shadow_q [BYTES];
    logic [BYTES-1:0] written_q;

    // Slot s belongs to channel s/BYTES and must see stores of strictly lower channels only.
    always_comb begin
        rd_written = '0;
        rd_data    = '0;
        for (int s = 0; s < NSLOT; s++) begin
            rd_written[s]     = written_q[lane[s*LANE_W +: LANE_W]];
            rd_data[s*8 +: 8] = shadow_q[lane[s*LANE_W +: LANE_W]];
            for (int t = 0; t < NSLOT; t++) begin
                if ((t / BYTES) < (s / BYTES) && wr_hit[t] &&
                    lane[t*LANE_W +: LANE_W] == lane[s*LANE_W +: LANE_W]) begin
                    rd_written[s]     = 1'b1;
                    rd_data[s*8 +: 8] = wdata[t*8 +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking updates in slot order, so the last (highest channel) store to a lane wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            written_q <= '0;
        end else begin
            for (int t = 0; t < NSLOT; t++) begin
                if (wr_hit[t]) begin
                    written_q[lane[t*LANE_W +: LANE_W]] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int t = 0; t < NSLOT; t++) begin
                if (wr_hit[t]) begin
                    shadow_q[lane[t*LANE_W +: LANE_W]] <= wdata[t*8 +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/rvfi_dmem_multi_check.sv
// RVFI data-memory consistency checker over NADDR shadowed words and NRET retire channels,
// reporting mismatches as an immediate assertion and as registered sticky status.
module rvfi_dmem_multi_check
    import rvfi_dmem_check_pkg::*;
#(
    parameter int                    XLEN       = 32,
    parameter int                    NRET       = 1,
    parameter int                    NADDR      = 2,
    parameter int                    ASSERT_EN  = 1,
    parameter int                    CNT_W      = 16,
    // Tracked addresses in simulation; formal builds pick them as solver constants.
    parameter logic [NADDR*XLEN-1:0] TRACK_ADDR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    output logic [NADDR*XLEN-1:0]  dmem_addr,
    input  logic [NRET-1:0]        rvfi_valid,
    input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
    input  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
    output logic                   err,
    output logic [$clog2(NRET):0]  err_chan,
    output logic [XLEN-1:0]        err_addr,
    output logic [CNT_W-1:0]       chk_cnt
);
    localparam int NSLOT  = NRET * BYTES;
    localparam int CHAN_W = $clog2(NRET) + 1;

`ifdef FORMAL
    (* anyconst *) logic [NADDR*XLEN-1:0] dmem_addr_raw;
`else
    logic [NADDR*XLEN-1:0] dmem_addr_raw;
    assign dmem_addr_raw = TRACK_ADDR;
`endif

    always_comb begin
        dmem_addr = '0;
        for (int n = 0; n < NADDR; n++) begin
            dmem_addr[n*XLEN +: XLEN] = word_of(dmem_addr_raw[n*XLEN +: XLEN]);
        end
    end

    // Slot s = channel*BYTES + byte; its mask bit and data byte share index s on the flat buses.
    logic [XLEN-1:0]         slot_addr  [NSLOT];
    logic [NSLOT*LANE_W-1:0] slot_lane;
    logic [NSLOT-1:0]        wr_hit     [NADDR];
    logic [NSLOT-1:0]        rd_hit     [NADDR];
    logic [NSLOT-1:0]        rd_written [NADDR];
    logic [NSLOT*8-1:0]      rd_data    [NADDR];

    always_comb begin
        slot_lane = '0;
        for (int n = 0; n < NADDR; n++) begin
            wr_hit[n] = '0;
            rd_hit[n] = '0;
        end
        for (int c = 0; c < NRET; c++) begin
            for (int i = 0; i < BYTES; i++) begin
                slot_addr[c*BYTES+i] = rvfi_mem_addr[c*XLEN +: XLEN] + XLEN'(i);
                slot_lane[(c*BYTES+i)*LANE_W +: LANE_W] = lane_of(slot_addr[c*BYTES+i]);
                for (int n = 0; n < NADDR; n++) begin
                    if (rvfi_valid[c] && `RVFORMAL_ADDR_VALID(slot_addr[c*BYTES+i]) &&
                        word_of(slot_addr[c*BYTES+i]) == dmem_addr[n*XLEN +: XLEN]) begin
                        wr_hit[n][c*BYTES+i] = rvfi_mem_wmask[c*BYTES+i];
                        rd_hit[n][c*BYTES+i] = enable && rvfi_mem_rmask[c*BYTES+i];
                    end
                end
            end
        end
    end

    for (genvar n = 0; n < NADDR; n++) begin : g_word
        rvfi_dmem_shadow_word #(
            .NRET(NRET)
        ) u_word (
            .clock      (clock),
            .reset      (reset),
            .wr_hit     (wr_hit[n]),
            .lane       (slot_lane),
            .wdata      (rvfi_mem_wdata),
            .rd_written (rd_written[n]),
            .rd_data    (rd_data[n])
        );
    end

    logic              fail_any;
    logic [CHAN_W-1:0] fail_chan;
    logic [XLEN-1:0]   fail_addr;
    logic [CNT_W:0]    num_chk;
    logic [CNT_W:0]    cnt_sum;

    // Walk slots from highest to lowest so the lowest channel, then lowest byte, is left captured.
    always_comb begin
        num_chk   = '0;
        fail_any  = 1'b0;
        fail_chan = '0;
        fail_addr = '0;
        for (int s = NSLOT - 1; s >= 0; s--) begin
            for (int n = 0; n < NADDR; n++) begin
                if (rd_hit[n][s] && rd_written[n][s]) begin
                    num_chk = num_chk + (CNT_W+1)'(1);
                    if (rd_data[n][s*8 +: 8] != rvfi_mem_rdata[s*8 +: 8]) begin
                        fail_any  = 1'b1;
                        fail_chan = CHAN_W'(s / BYTES);
                        fail_addr = slot_addr[s];
                    end
                end
            end
        end
    end

    assign cnt_sum = {1'b0, chk_cnt} + num_chk;

    if (ASSERT_EN != 0) begin : g_assert
        always_comb begin
            if (!reset) begin
                assert (!fail_any);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err      <= 1'b0;
            err_chan <= '0;
            err_addr <= '0;
            chk_cnt  <= '0;
        end else begin
            chk_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            if (fail_any && !err) begin
                err      <= 1'b1;
                err_chan <= fail_chan;
                err_addr <= fail_addr;
            end
        end
    end
endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Scoreboard bench: a byte-addressed reference model predicts the status after every cycle.
module tb_rvfi_dmem_multi_check;
    localparam int          XLEN  = 32;
    localparam int          NRET  = 2;
    localparam int          NADDR = 2;
    localparam logic [31:0] TA0   = 32'h0000_0100;
    localparam logic [31:0] TA1   = 32'h0000_0104;

    typedef struct packed {
        bit        v;
        bit [31:0] addr;
        bit [3:0]  rmask;
        bit [3:0]  wmask;
        bit [31:0] rdata;
        bit [31:0] wdata;
    } ch_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  chan;
        logic [31:0] addr;
        logic [15:0] cnt;
    } status_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] dmem_addr;
    logic [1:0]  rvfi_valid;
    logic [63:0] rvfi_mem_addr;
    logic [7:0]  rvfi_mem_rmask;
    logic [7:0]  rvfi_mem_wmask;
    logic [63:0] rvfi_mem_rdata;
    logic [63:0] rvfi_mem_wdata;
    logic        err;
    logic [1:0]  err_chan;
    logic [31:0] err_addr;
    logic [15:0] chk_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    status_t exp_q[$];
    status_t obs_q[$];

    bit [7:0]  m_mem [bit [31:0]];
    bit        m_err;
    bit [1:0]  m_chan;
    bit [31:0] m_addr;
    bit [15:0] m_cnt;

    always #5 clock = ~clock;

    rvfi_dmem_multi_check #(
        .XLEN       (XLEN),
        .NRET       (NRET),
        .NADDR      (NADDR),
        .ASSERT_EN  (0),
        .CNT_W      (16),
        .TRACK_ADDR ({TA1, TA0})
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .dmem_addr      (dmem_addr),
        .rvfi_valid     (rvfi_valid),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .err            (err),
        .err_chan       (err_chan),
        .err_addr       (err_addr),
        .chk_cnt        (chk_cnt)
    );

    function automatic bit tracked(input bit [31:0] a);
        return ((a & ~32'h3) == TA0) || ((a & ~32'h3) == TA1);
    endfunction

    function automatic ch_t idle();
        ch_t c;
        c = '0;
        return c;
    endfunction

    function automatic ch_t acc(input bit [31:0] addr, input bit [3:0] rmask, input bit [31:0] rdata,
                                input bit [3:0] wmask, input bit [31:0] wdata);
        ch_t c;
        c.v = 1'b1;
        c.addr = addr;
        c.rmask = rmask;
        c.rdata = rdata;
        c.wmask = wmask;
        c.wdata = wdata;
        return c;
    endfunction

    function automatic ch_t ld(input bit [31:0] addr, input bit [3:0] rmask, input bit [31:0] rdata);
        return acc(addr, rmask, rdata, 4'h0, 32'h0);
    endfunction

    function automatic ch_t st(input bit [31:0] addr, input bit [3:0] wmask, input bit [31:0] wdata);
        return acc(addr, 4'h0, 32'h0, wmask, wdata);
    endfunction

    // Drive one retire cycle, predict the status after the edge, then sample the DUT.
    task automatic cycle(input ch_t c0, input ch_t c1, input bit rst, input bit en);
        ch_t       ch [2];
        bit        seen;
        bit [31:0] a;
        status_t   s;
        ch[0] = c0;
        ch[1] = c1;
        reset          = rst;
        enable         = en;
        rvfi_valid     = {c1.v, c0.v};
        rvfi_mem_addr  = {c1.addr, c0.addr};
        rvfi_mem_rmask = {c1.rmask, c0.rmask};
        rvfi_mem_wmask = {c1.wmask, c0.wmask};
        rvfi_mem_rdata = {c1.rdata, c0.rdata};
        rvfi_mem_wdata = {c1.wdata, c0.wdata};
        if (rst) begin
            m_mem.delete();
            m_err  = 1'b0;
            m_chan = '0;
            m_addr = '0;
            m_cnt  = '0;
        end else begin
            seen = m_err;
            for (int c = 0; c < 2; c++) begin
                if (ch[c].v) begin
                    for (int i = 0; i < 4; i++) begin
                        a = ch[c].addr + 32'(i);
                        if (en && ch[c].rmask[i] && tracked(a) && m_mem.exists(a)) begin
                            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                            if (m_mem[a] != ch[c].rdata[i*8 +: 8] && !seen) begin
                                seen   = 1'b1;
                                m_err  = 1'b1;
                                m_chan = 2'(c);
                                m_addr = a;
                            end
                        end
                    end
                    for (int i = 0; i < 4; i++) begin
                        a = ch[c].addr + 32'(i);
                        if (ch[c].wmask[i] && tracked(a)) m_mem[a] = ch[c].wdata[i*8 +: 8];
                    end
                end
            end
        end
        exp_q.push_back({m_err, m_chan, m_addr, m_cnt});
        @(posedge clock);
        #1;
        s = {err, err_chan, err_addr, chk_cnt};
        obs_q.push_back(s);
    endtask

    task automatic test_reset();
        status_t e, o;
        int k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(idle(), idle(), 1'b1, 1'b1);
        n_asserts++;
        if (dmem_addr !== {TA1, TA0}) begin
            n_fail++;
            $display("FAIL reset dmem_addr: got %h expected %h", dmem_addr, {TA1, TA0});
        end
        n_asserts++;
        if ({err, err_chan, err_addr, chk_cnt} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset status: got err=%0b chan=%0d addr=%h cnt=%0d expected all zero",
                     err, err_chan, err_addr, chk_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_store_load();
        status_t e, o;
        int k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(st(32'h100, 4'hF, 32'hA1B2_C3D4), idle(), 1'b0, 1'b1);
        cycle(ld(32'h100, 4'hF, 32'hA1B2_C3D4), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL store_load: got err=%0b cnt=%0d expected err=0 cnt=4", err, chk_cnt);
        end
        // Load and store on the same channel: the read sees pre-store data.
        cycle(acc(32'h100, 4'h1, 32'h0000_00D4, 4'h1, 32'h0000_0099), idle(), 1'b0, 1'b1);
        cycle(ld(32'h100, 4'h1, 32'h0000_0099), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL same_channel: got err=%0b cnt=%0d expected err=0 cnt=6", err, chk_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL store_load[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_mismatch();
        status_t e, o;
        int k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(st(32'h100, 4'hF, 32'hA1B2_C3D4), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch pre: got err=%0b expected 0", err);
        end
        cycle(ld(32'h100, 4'hF, 32'hA1B2_C3D5), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b1 || err_chan !== 2'd0 || err_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL mismatch capture: got err=%0b chan=%0d addr=%h expected err=1 chan=0 addr=100",
                     err, err_chan, err_addr);
        end
        // A later mismatch on another channel must not move the capture.
        cycle(idle(), ld(32'h103, 4'h1, 32'h0000_0000), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b1 || err_chan !== 2'd0 || err_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL mismatch sticky: got err=%0b chan=%0d addr=%h expected err=1 chan=0 addr=100",
                     err, err_chan, err_addr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mismatch[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_misaligned();
        status_t e, o;
        int k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(st(32'h102, 4'hF, 32'h1122_3344), idle(), 1'b0, 1'b1);
        cycle(ld(32'h104, 4'h3, 32'h0000_1122), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL misaligned load: got err=%0b cnt=%0d expected err=0 cnt=2", err, chk_cnt);
        end
        // Only lanes 2-3 of 0x100 and lanes 0-1 of 0x104 are written, so each full load adds 2.
        cycle(ld(32'h100, 4'hF, 32'h3344_BEEF), idle(), 1'b0, 1'b1);
        cycle(ld(32'h104, 4'hF, 32'hDEAD_1122), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL misaligned lanes: got err=%0b cnt=%0d expected err=0 cnt=6", err, chk_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL misaligned[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_same_cycle();
        status_t e, o;
        int k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(st(32'h101, 4'h1, 32'h0000_0055), ld(32'h101, 4'h1, 32'h0000_0055), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL same_cycle pass: got err=%0b cnt=%0d expected err=0 cnt=1", err, chk_cnt);
        end
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(st(32'h101, 4'h1, 32'h0000_0077), idle(), 1'b0, 1'b1);
        cycle(st(32'h101, 4'h1, 32'h0000_0055), ld(32'h101, 4'h1, 32'h0000_0077), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b1 || err_chan !== 2'd1 || err_addr !== 32'h101) begin
            n_fail++;
            $display("FAIL same_cycle stale: got err=%0b chan=%0d addr=%h expected err=1 chan=1 addr=101",
                     err, err_chan, err_addr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL same_cycle[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_unwritten_and_reset();
        status_t e, o;
        int k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        cycle(ld(32'h100, 4'hF, 32'h1234_5678), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL unwritten: got err=%0b cnt=%0d expected err=0 cnt=0", err, chk_cnt);
        end
        // Store, reset (with a store discarded in the reset cycle), then load wrong data.
        cycle(st(32'h100, 4'hF, 32'hA1B2_C3D4), idle(), 1'b0, 1'b1);
        cycle(st(32'h104, 4'hF, 32'h0BAD_F00D), idle(), 1'b1, 1'b1);
        cycle(ld(32'h100, 4'hF, 32'h0000_0000), ld(32'h104, 4'hF, 32'h0000_0000), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_clears: got err=%0b cnt=%0d expected err=0 cnt=0", err, chk_cnt);
        end
        // Disabled cycles still store but never compare.
        cycle(st(32'h104, 4'hF, 32'hCAFE_BABE), idle(), 1'b0, 1'b0);
        cycle(ld(32'h104, 4'hF, 32'h0000_0000), idle(), 1'b0, 1'b0);
        cycle(ld(32'h104, 4'hF, 32'hCAFE_BABE), idle(), 1'b0, 1'b1);
        n_asserts++;
        if (err !== 1'b0 || chk_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL enable_gate: got err=%0b cnt=%0d expected err=0 cnt=4", err, chk_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL unwritten_reset[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        status_t   e, o;
        ch_t       ch [2];
        bit [31:0] a;
        int        k = 0;
        cycle(idle(), idle(), 1'b1, 1'b1);
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                ch[c].v     = ($urandom_range(0, 4) != 0);
                ch[c].addr  = 32'h0F8 + 32'($urandom_range(0, 20));
                ch[c].rmask = 4'($urandom);
                ch[c].wmask = 4'($urandom);
                ch[c].wdata = $urandom;
                ch[c].rdata = $urandom;
                for (int i = 0; i < 4; i++) begin
                    a = ch[c].addr + 32'(i);
                    if (m_mem.exists(a) && $urandom_range(0, 15) != 0) ch[c].rdata[i*8 +: 8] = m_mem[a];
                end
            end
            cycle(ch[0], ch[1], ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_asserts++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got err=%0b chan=%0d addr=%h cnt=%0d expected err=%0b chan=%0d addr=%h cnt=%0d",
                         k, o.err, o.chan, o.addr, o.cnt, e.err, e.chan, e.addr, e.cnt);
            end
            k++;
        end
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        rvfi_valid     = '0;
        rvfi_mem_addr  = '0;
        rvfi_mem_rmask = '0;
        rvfi_mem_wmask = '0;
        rvfi_mem_rdata = '0;
        rvfi_mem_wdata = '0;
        #1;
        test_reset();
        test_store_load();
        test_mismatch();
        test_misaligned();
        test_same_cycle();
        test_unwritten_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
